// File: rtl/serial_adder.sv
// serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per clock
// behind a start/busy/done handshake, reporting carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Ripple of DIGIT full adders; returns {carry into digit MSB, carry out, sum bits}.
  function automatic logic [DIGIT+1:0] add_digit(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             ci);
    logic [DIGIT-1:0] s;
    logic             c;
    logic             c_msb;
    s     = '0;
    c     = ci;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_msb, c, s};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [DIGIT+1:0] digit_res;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    psum_d    = psum_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    digit_res = add_digit(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = digit_res[DIGIT];
        psum_d  = (psum_q >> DIGIT) | (WIDTH'(digit_res[DIGIT-1:0]) << (WIDTH - DIGIT));
        step_d  = step_q + CNT_W'(1);
        // Final digit: its MSB carry-in is the carry into bit WIDTH-1.
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          sum_d   = psum_d;
          cout_d  = digit_res[DIGIT];
          ovf_d   = digit_res[DIGIT+1] ^ digit_res[DIGIT];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand shifters and partial sum are fully reloaded by every operation.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    carry_q <= carry_d;
    psum_q  <= psum_d;
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: several parameterisations run side by side,
// each with its own driver, expected-result queue and done-triggered monitor.
module tb_serial_adder;
  localparam int NL = 7;
  localparam int W_OF [NL] = '{8, 8, 1, 16, 16, 16, 16};
  localparam int D_OF [NL] = '{1, 4, 1, 1, 2, 4, 16};
  localparam int SWEEP_OPS = 125;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  wire [NL-1:0] lane_fin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    localparam int W = W_OF[gi];
    localparam int D = D_OF[gi];
    localparam int N = W / D;

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;
    logic [W+1:0] exp_q [$];
    logic [W+1:0] last_res  = '0;
    int           busy_run  = 0;
    logic         done_prev = 1'b0;
    bit           fin       = 1'b0;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .reset (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
    );

    assign lane_fin[gi] = fin;

    // Reference: {ovf, cout, sum} from plain wide arithmetic and sign rules.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic ci);
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         o;
      if (s) full = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
      else   full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r = full[W-1:0];
      if (s) o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      else   o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      return {o, full[W], r};
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic ci, input logic [W+1:0] e);
      @(negedge clk);
      a = x; b = y; sub = s; cin = ci; start = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; a = ~x; b = x ^ y; sub = ~s; cin = ~ci;
      repeat (N) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
      check($sformatf("L%0d %s busy/done/cout/ovf", gi, tag), 32'({busy, done, cout, ovf}), 32'(0));
      check($sformatf("L%0d %s sum", gi, tag), 32'(sum), 32'(0));
    endtask

    initial forever begin : mon
      @(negedge clk);
      if (rst) begin
        busy_run  = 0;
        done_prev = 1'b0;
        last_res  = '0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          check($sformatf("L%0d busy with done", gi), 32'(busy), 32'(0));
          check($sformatf("L%0d done width", gi), 32'(done_prev), 32'(0));
          check($sformatf("L%0d busy length", gi), 32'(busy_run), 32'(N));
          busy_run = 0;
          check($sformatf("L%0d done expected", gi), 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) begin
            last_res = exp_q.pop_front();
            check($sformatf("L%0d result {ovf,cout,sum}", gi), 32'({ovf, cout, sum}), 32'(last_res));
          end
        end else begin
          check($sformatf("L%0d outputs hold", gi), 32'({ovf, cout, sum}), 32'(last_res));
        end
        done_prev = done;
      end
    end

    if (gi == 0) begin : g_w8d1
      initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;
        issue(8'h3C, 8'h0F, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4B});
        issue(8'hFF, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h01});
        issue(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
        // start held high with operands changing every cycle
        for (int k = 0; k < 3 * (N + 2); k++) begin
          @(negedge clk);
          start = 1'b1;
          a = W'(k * 37 + 5); b = W'(k * 91 + 11);
          sub = 1'(k % 2); cin = 1'((k / 2) % 2);
          if (k % (N + 2) == 0) exp_q.push_back(model(a, b, sub, cin));
        end
        @(negedge clk); start = 1'b0;
        repeat (N + 2) @(negedge clk);
        // abort mid-RUN: no done may follow
        @(negedge clk); a = 8'hC3; b = 8'h5A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_zero("mid-run reset");
        @(negedge clk); #1 rst = 1'b0;
        repeat (N + 2) @(negedge clk);
        issue(8'h5A, 8'h33, 1'b1, 1'b0, {1'b0, 1'b1, 8'h27});
        repeat (4) @(negedge clk);
        check("L0 pending results", 32'(exp_q.size()), 32'(0));
        fin = 1'b1;
      end
    end else if (gi == 1) begin : g_w8d4
      initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;
        issue(8'h05, 8'h07, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFE});
        issue(8'h80, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h7F});
        issue(8'hA5, 8'h5A, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00});
        repeat (4) @(negedge clk);
        check("L1 pending results", 32'(exp_q.size()), 32'(0));
        fin = 1'b1;
      end
    end else if (gi == 2) begin : g_w1d1
      initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 3'b011);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        issue(1'b0, 1'b1, 1'b1, 1'b0, 3'b101);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 3'b010);
        repeat (4) @(negedge clk);
        check("L2 pending results", 32'(exp_q.size()), 32'(0));
        fin = 1'b1;
      end
    end else begin : g_sweep
      initial begin : drv
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic         ci;
        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;
        for (int k = 0; k < SWEEP_OPS; k++) begin
          x = W'($urandom); y = W'($urandom);
          s = 1'($urandom); ci = 1'($urandom);
          if (k == 0) begin x = '1; y = '1; s = 1'b0; ci = 1'b1; end
          if (k == 1) begin x = '0; x[W-1] = 1'b1; y = W'(1); s = 1'b1; end
          if (k == 2) begin x = '1; x[W-1] = 1'b0; y = '0; y[W-1] = 1'b1; s = 1'b1; end
          issue(x, y, s, ci, model(x, y, s, ci));
        end
        repeat (4) @(negedge clk);
        check($sformatf("L%0d pending results", gi), 32'(exp_q.size()), 32'(0));
        fin = 1'b1;
      end
    end
  end

  initial begin
    fork
      wait (&lane_fin);
      #500000;
    join_any
    disable fork;
    check("all lanes finished", 32'(&lane_fin), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
